// File: rtl/bus_responder.sv
// Memory-side responder for the request/grant bus: round-robin arbitration between two
// initiators, a word-addressed RAM and single-cycle active-low grants after a programmable wait.
module bus_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  m0_breq_,
  input  logic                  m0_memread,
  input  logic                  m0_memwrite,
  input  logic [ADDR_WIDTH-1:0] m0_adr,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic                  m0_bgrt_,
  input  logic                  m1_breq_,
  input  logic                  m1_memread,
  input  logic                  m1_memwrite,
  input  logic [ADDR_WIDTH-1:0] m1_adr,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic                  m1_bgrt_,
  output logic [DATA_WIDTH-1:0] memdata,
  output logic                  busy
);

  // state | meaning
  // IDLE  | sample requests, pick owner, latch its transfer
  // WAIT  | count down the programmed wait cycles
  // GRANT | one-cycle grant pulse to the owner; write commits on exit
  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    owner;
  logic                    last_owner;
  logic                    op_write;
  logic [ADDR_WIDTH-1:0]   lat_adr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic                    req0;
  logic                    req1;
  logic                    sel;
  logic [ADDR_WIDTH-1:0]   sel_adr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_write;

  // The write strobe alone decides the operation; memread carries no extra information.
  logic unused_strobes;
  assign unused_strobes = m0_memread ^ m1_memread;

  always_comb begin
    req0      = !m0_breq_;
    req1      = !m1_breq_;
    sel       = 1'b0;
    if (req0 && req1) sel = !last_owner;
    else if (req1)    sel = 1'b1;
    sel_adr   = sel ? m1_adr       : m0_adr;
    sel_wdata = sel ? m1_writedata : m0_writedata;
    sel_write = sel ? m1_memwrite  : m0_memwrite;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      op_write   <= 1'b0;
      lat_adr    <= '0;
      lat_wdata  <= '0;
      m0_bgrt_   <= 1'b1;
      m1_bgrt_   <= 1'b1;
      memdata    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= sel;
            lat_adr   <= sel_adr;
            lat_wdata <= sel_wdata;
            op_write  <= sel_write;
            cnt       <= 4'(WAIT_CYCLES);
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state    <= GRANT;
              m0_bgrt_ <= sel;
              m1_bgrt_ <= !sel;
              if (!sel_write) memdata <= mem[sel_adr];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= GRANT;
            m0_bgrt_ <= owner;
            m1_bgrt_ <= !owner;
            if (!op_write) memdata <= mem[lat_adr];
          end
        end
        GRANT: begin
          state      <= IDLE;
          m0_bgrt_   <= 1'b1;
          m1_bgrt_   <= 1'b1;
          busy       <= 1'b0;
          last_owner <= owner;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (state == GRANT && op_write) mem[lat_adr] <= lat_wdata;
  end

  assert property (@(posedge clk) disable iff (!reset_) (m0_bgrt_ || m1_bgrt_));

endmodule
